// File: rtl/qam16_pkg.sv
// qam16_pkg -- shared constants and types for the 16-QAM demodulator.
//   SAMPLE_W / LUT_W : modulated sample width and carrier LUT width
//   L_*              : 2-bit per-axis level codes
//   I_MSB..Q_LSB     : bit positions in the interleaved 4-bit symbol
//   demod_state_e    : integrate-and-dump FSM states
//   cos_lut()        : 16-entry cosine table, amplitude 127
package qam16_pkg;

  localparam int SAMPLE_W  = 9;
  localparam int LUT_W     = 8;
  localparam int LUT_DEPTH = 16;

  localparam logic [1:0] L_NEG3 = 2'b00;
  localparam logic [1:0] L_NEG1 = 2'b01;
  localparam logic [1:0] L_POS1 = 2'b10;
  localparam logic [1:0] L_POS3 = 2'b11;

  localparam int I_MSB = 3;
  localparam int Q_MSB = 2;
  localparam int I_LSB = 1;
  localparam int Q_LSB = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    INTEG = 1'b1
  } demod_state_e;

  // round(127*cos(2*pi*k/16)); sin[k] is read as cos[(k+12) mod 16].
  function automatic logic signed [LUT_W-1:0] cos_lut(input logic [3:0] k);
    case (k)
      4'd0:    return  8'sd127;
      4'd1:    return  8'sd117;
      4'd2:    return  8'sd90;
      4'd3:    return  8'sd49;
      4'd4:    return  8'sd0;
      4'd5:    return -8'sd49;
      4'd6:    return -8'sd90;
      4'd7:    return -8'sd117;
      4'd8:    return -8'sd127;
      4'd9:    return -8'sd117;
      4'd10:   return -8'sd90;
      4'd11:   return -8'sd49;
      4'd12:   return  8'sd0;
      4'd13:   return  8'sd49;
      4'd14:   return  8'sd90;
      default: return  8'sd117;
    endcase
  endfunction

endpackage

// File: rtl/demod_slicer.sv
// demod_slicer -- combinational 4-level slicer for one axis integral.
//   acc_i : signed integral (ACC_W bits)
//   lvl_o : level code L_NEG3 / L_NEG1 / L_POS1 / L_POS3
module demod_slicer
  import qam16_pkg::*;
#(
  parameter int          ACC_W  = 23,
  parameter int unsigned THRESH = 262144
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [1:0]       lvl_o
);

  localparam logic signed [ACC_W-1:0] T_POS = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] T_NEG = -T_POS;

  always_comb begin
    if (acc_i < T_NEG)        lvl_o = L_NEG3;
    else if (acc_i[ACC_W-1])  lvl_o = L_NEG1;
    else if (acc_i < T_POS)   lvl_o = L_POS1;
    else                      lvl_o = L_POS3;
  end

endmodule

// File: rtl/demod_16qam.sv
// demod_16qam -- coherent 16-QAM integrate-and-dump demodulator.
//   clk, reset_n     : carrier-rate clock, synchronous active-low reset
//   sync, in_valid   : symbol-alignment strobe (qualified by in_valid), sample valid
//   mod_in           : signed 9-bit modulated sample
//   sym_out          : sliced symbol {I[1],Q[1],I[0],Q[0]}
//   sym_valid        : one-cycle pulse when sym_out/i_soft/q_soft are new
//   i_soft, q_soft   : signed I/Q integrals of the last symbol
//   sat_flag         : (only with DEMOD_ACC_SAT_EN) an accumulate clipped in the last symbol
// Build option: define DEMOD_ACC_SAT_EN for saturating accumulation; otherwise
// the accumulators wrap modulo 2^ACC_W.
module demod_16qam
  import qam16_pkg::*;
#(
  parameter int          CARR_LEN = 16,
  parameter int          SYM_LEN  = 64,
  parameter int          ACC_W    = 23,
  parameter int unsigned THRESH   = 262144
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sync,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] mod_in,
  output logic        [3:0]          sym_out,
  output logic                       sym_valid,
  output logic signed [ACC_W-1:0]    i_soft,
  output logic signed [ACC_W-1:0]    q_soft
`ifdef DEMOD_ACC_SAT_EN
  ,
  output logic                       sat_flag
`endif
);

  localparam int CNT_W    = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam int PROD_W   = SAMPLE_W + LUT_W;
  // The table holds 16 points; shorter carrier periods stride through it.
  localparam int TAB_STEP = LUT_DEPTH / CARR_LEN;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYM_LEN - 1);

  demod_state_e             state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [3:0]               sym_q, sym_d;
  logic                     vld_q, vld_d;
  logic signed [ACC_W-1:0]  isoft_q, isoft_d, qsoft_q, qsoft_d;

  logic                     accept, first, last;
  logic [CNT_W-1:0]         eff_cnt;
  logic [3:0]               tab_idx;
  logic signed [LUT_W-1:0]  cos_v, sin_v;
  logic signed [PROD_W-1:0] prod_i, prod_q;
  logic signed [ACC_W-1:0]  p_i, p_q, sum_i, sum_q;
  logic [1:0]               lvl_i, lvl_q;

  function automatic logic signed [ACC_W:0] add_wide(input logic signed [ACC_W-1:0] a,
                                                     input logic signed [ACC_W-1:0] b);
    return {a[ACC_W-1], a} + {b[ACC_W-1], b};
  endfunction

`ifdef DEMOD_ACC_SAT_EN
  function automatic logic signed [ACC_W-1:0] sat_trunc(input logic signed [ACC_W:0] s);
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  logic                    sat_run_q, sat_run_d, sat_flag_q, sat_flag_d;
  logic signed [ACC_W:0]   wide_i, wide_q;
  logic                    clip_any, sat_now;
`endif

  // Accept / symbol-boundary decode. A sync on the last sample of a symbol
  // does not restart it: that sample still closes the old symbol.
  always_comb begin
    accept = 1'b0;
    first  = 1'b0;
    if (in_valid) begin
      if (state_q == IDLE) begin
        accept = sync;
        first  = sync;
      end else begin
        accept = 1'b1;
        first  = (cnt_q == '0) || (sync && (cnt_q != LAST_CNT));
      end
    end
  end

  assign eff_cnt = first ? '0 : cnt_q;
  assign last    = (eff_cnt == LAST_CNT);
  assign tab_idx = 4'((int'(eff_cnt) % CARR_LEN) * TAB_STEP);
  assign cos_v   = cos_lut(tab_idx);
  assign sin_v   = cos_lut(tab_idx + 4'd12);
  assign prod_i  = mod_in * cos_v;
  assign prod_q  = mod_in * sin_v;
  assign p_i     = ACC_W'(prod_i);
  assign p_q     = ACC_W'(prod_q);

`ifdef DEMOD_ACC_SAT_EN
  assign wide_i   = add_wide(acc_i_q, p_i);
  assign wide_q   = add_wide(acc_q_q, p_q);
  assign clip_any = !first && ((wide_i[ACC_W] != wide_i[ACC_W-1]) ||
                               (wide_q[ACC_W] != wide_q[ACC_W-1]));
  assign sat_now  = (!first && sat_run_q) || clip_any;
  assign sum_i    = first ? p_i : sat_trunc(wide_i);
  assign sum_q    = first ? p_q : sat_trunc(wide_q);
`else
  logic signed [ACC_W:0] wide_i, wide_q;
  assign wide_i = add_wide(acc_i_q, p_i);
  assign wide_q = add_wide(acc_q_q, p_q);
  assign sum_i  = first ? p_i : wide_i[ACC_W-1:0];
  assign sum_q  = first ? p_q : wide_q[ACC_W-1:0];
`endif

  demod_slicer #(.ACC_W(ACC_W), .THRESH(THRESH)) u_slice_i (.acc_i(sum_i), .lvl_o(lvl_i));
  demod_slicer #(.ACC_W(ACC_W), .THRESH(THRESH)) u_slice_q (.acc_i(sum_q), .lvl_o(lvl_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    sym_d   = sym_q;
    isoft_d = isoft_q;
    qsoft_d = qsoft_q;
    vld_d   = 1'b0;
    if (accept) begin
      state_d = INTEG;
      cnt_d   = last ? '0 : eff_cnt + CNT_W'(1);
      acc_i_d = sum_i;
      acc_q_d = sum_q;
      if (last) begin
        vld_d        = 1'b1;
        sym_d[I_MSB] = lvl_i[1];
        sym_d[Q_MSB] = lvl_q[1];
        sym_d[I_LSB] = lvl_i[0];
        sym_d[Q_LSB] = lvl_q[0];
        isoft_d      = sum_i;
        qsoft_d      = sum_q;
      end
    end
  end

`ifdef DEMOD_ACC_SAT_EN
  always_comb begin
    sat_run_d  = sat_run_q;
    sat_flag_d = sat_flag_q;
    if (accept) begin
      sat_run_d = sat_now;
      if (last) sat_flag_d = sat_now;
    end
  end
`endif

  // Stage boundary: all state and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_i_q <= '0;
      acc_q_q <= '0;
      sym_q   <= '0;
      vld_q   <= 1'b0;
      isoft_q <= '0;
      qsoft_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
      sym_q   <= sym_d;
      vld_q   <= vld_d;
      isoft_q <= isoft_d;
      qsoft_q <= qsoft_d;
    end
  end

`ifdef DEMOD_ACC_SAT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sat_run_q  <= 1'b0;
      sat_flag_q <= 1'b0;
    end else begin
      sat_run_q  <= sat_run_d;
      sat_flag_q <= sat_flag_d;
    end
  end
  assign sat_flag = sat_flag_q;
`endif

  assign sym_out   = sym_q;
  assign sym_valid = vld_q;
  assign i_soft    = isoft_q;
  assign q_soft    = qsoft_q;

endmodule

// File: tb/tb_demod_16qam.sv
// tb_demod_16qam -- self-checking bench for demod_16qam.
// Honours DEMOD_ACC_SAT_EN (builds the DUT with ACC_W=20 and checks sat_flag).
module tb_demod_16qam;

  localparam int CARR_LEN = 16;
  localparam int SYM_LEN  = 64;
`ifdef DEMOD_ACC_SAT_EN
  localparam int ACC_W    = 20;
`else
  localparam int ACC_W    = 23;
`endif
  localparam int THRESH   = 262144;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    sync = 1'b0;
  logic                    in_valid = 1'b0;
  logic signed [8:0]       mod_in = '0;
  logic [3:0]              sym_out;
  logic                    sym_valid;
  logic signed [ACC_W-1:0] i_soft, q_soft;
  logic                    sat_flag;

  always #5 clk = ~clk;

  demod_16qam #(.CARR_LEN(CARR_LEN), .SYM_LEN(SYM_LEN), .ACC_W(ACC_W), .THRESH(THRESH)) dut (
    .clk(clk), .reset_n(reset_n), .sync(sync), .in_valid(in_valid), .mod_in(mod_in),
    .sym_out(sym_out), .sym_valid(sym_valid), .i_soft(i_soft), .q_soft(q_soft)
`ifdef DEMOD_ACC_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );
`ifndef DEMOD_ACC_SAT_EN
  assign sat_flag = 1'b0;
`endif

  typedef struct {
    logic [3:0]              sym;
    logic signed [ACC_W-1:0] i;
    logic signed [ACC_W-1:0] q;
    logic                    sat;
    int                      cyc;
  } dump_t;

  dump_t got_q[$];
  dump_t exp_q[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    cyc = 0;
  int    cosv[CARR_LEN];
  int    sinv[CARR_LEN];

  // Reference model: symbol-level integrate-and-dump on plain integers.
  bit     m_act;
  int     m_n;
  longint m_ai, m_aq;
  bit     m_sat;

  function automatic longint acc_upd(input longint a, input longint p, inout bit clip);
    longint s;
    longint half;
    s    = a + p;
    half = longint'(1) << (ACC_W - 1);
`ifdef DEMOD_ACC_SAT_EN
    if (s > half - 1) begin s = half - 1; clip = 1'b1; end
    else if (s < -half) begin s = -half; clip = 1'b1; end
`else
    while (s >= half) s -= 2 * half;
    while (s < -half) s += 2 * half;
`endif
    return s;
  endfunction

  function automatic logic [1:0] slice(input longint a);
    if (a < -THRESH) return 2'b00;
    if (a < 0)       return 2'b01;
    if (a < THRESH)  return 2'b10;
    return 2'b11;
  endfunction

  function automatic void model_step(input bit s, input bit v, input int x);
    longint pi, pq;
    logic [1:0] li, lq;
    dump_t d;
    if (!v) return;
    if (!m_act) begin
      if (!s) return;
      m_act = 1'b1;
      m_n   = 0;
    end else if (s && m_n != SYM_LEN - 1) begin
      m_n = 0;
    end
    pi = longint'(x) * cosv[m_n % CARR_LEN];
    pq = longint'(x) * sinv[m_n % CARR_LEN];
    if (m_n == 0) begin
      m_ai = pi; m_aq = pq; m_sat = 1'b0;
    end else begin
      m_ai = acc_upd(m_ai, pi, m_sat);
      m_aq = acc_upd(m_aq, pq, m_sat);
    end
    m_n++;
    if (m_n == SYM_LEN) begin
      m_n   = 0;
      li    = slice(m_ai);
      lq    = slice(m_aq);
      d.sym = {li[1], lq[1], li[0], lq[0]};
      d.i   = ACC_W'(m_ai);
      d.q   = ACC_W'(m_aq);
`ifdef DEMOD_ACC_SAT_EN
      d.sat = m_sat;
`else
      d.sat = 1'b0;
`endif
      d.cyc = cyc;
      exp_q.push_back(d);
    end
  endfunction

  task automatic step(input bit s, input bit v, input int x);
    dump_t d;
    sync     = s;
    in_valid = v;
    mod_in   = 9'(x);
    cyc++;
    model_step(s, v, x);
    @(posedge clk);
    #1;
    if (sym_valid !== 1'b0) begin
      d.sym = sym_out; d.i = i_soft; d.q = q_soft; d.sat = sat_flag; d.cyc = cyc;
      got_q.push_back(d);
    end
  endtask

  function automatic int wave(input int kind, input int n);
    case (kind)
      0:       return cosv[n % CARR_LEN];
      1:       return -cosv[n % CARR_LEN];
      2:       return sinv[n % CARR_LEN];
      3:       return -sinv[n % CARR_LEN];
      4:       return (cosv[n % CARR_LEN] >= 0) ? 255 : -256;
      default: return int'($urandom_range(0, 511)) - 256;
    endcase
  endfunction

  // Drives SYM_LEN valid samples; invalid gap cycles carry random data and sync.
  task automatic send(input int kind, input int gap_pct, input bit sync_first, input bit sync_last);
    for (int n = 0; n < SYM_LEN; n++) begin
      while (int'($urandom_range(0, 99)) < gap_pct)
        step(bit'($urandom_range(0, 1)), 1'b0, int'($urandom_range(0, 511)) - 256);
      step((n == 0 && sync_first) || (n == SYM_LEN - 1 && sync_last), 1'b1, wave(kind, n));
    end
  endtask

  task automatic clear_q();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic pad_q(input int n);
    dump_t d;
    d.sym = 'x; d.i = 'x; d.q = 'x; d.sat = 1'bx; d.cyc = -1;
    while (got_q.size() < n) got_q.push_back(d);
    while (exp_q.size() < n) exp_q.push_back(d);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (sym_valid !== 1'b0) $display("FAIL rst0_vld got=%b want=0", sym_valid); else n_pass++;
    n_chk++; if (sym_out !== 4'b0) $display("FAIL rst0_sym got=%b want=0000", sym_out); else n_pass++;
    reset_n = 1'b1;
    m_act = 1'b0;
    send(0, 0, 1'b1, 1'b0);
    for (int n = 0; n < 20; n++) step(1'b0, 1'b1, wave(0, n));
    clear_q();
    sync = 1'b0; in_valid = 1'b1; mod_in = 9'sd100;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_act = 1'b0;
    n_chk++; if (sym_valid !== 1'b0) $display("FAIL rst_vld got=%b want=0", sym_valid); else n_pass++;
    n_chk++; if (sym_out !== 4'b0) $display("FAIL rst_sym got=%b want=0000", sym_out); else n_pass++;
    n_chk++; if (i_soft !== '0) $display("FAIL rst_isoft got=%0d want=0", i_soft); else n_pass++;
    n_chk++; if (q_soft !== '0) $display("FAIL rst_qsoft got=%0d want=0", q_soft); else n_pass++;
    n_chk++; if (sat_flag !== 1'b0) $display("FAIL rst_sat got=%b want=0", sat_flag); else n_pass++;
    send(0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0);
    send(0, 0, 1'b0, 1'b0);
    n_chk++; if (got_q.size() != 0) $display("FAIL rst_nosync_dumps got=%0d want=0", got_q.size()); else n_pass++;
  endtask

  task automatic test_cos();
    clear_q();
    send(0, 0, 1'b1, 1'b0);
    n_chk++; if (got_q.size() != 1) $display("FAIL cos_dumps got=%0d want=1", got_q.size()); else n_pass++;
    pad_q(1);
    n_chk++; if (got_q[0].sym !== 4'b1110) $display("FAIL cos_sym got=%b want=1110", got_q[0].sym); else n_pass++;
    n_chk++; if (got_q[0].i !== 516072) $display("FAIL cos_isoft got=%0d want=516072", got_q[0].i); else n_pass++;
    n_chk++; if (got_q[0].q !== 0) $display("FAIL cos_qsoft got=%0d want=0", got_q[0].q); else n_pass++;
    n_chk++; if (got_q[0].cyc !== exp_q[0].cyc) $display("FAIL cos_latency got=%0d want=%0d", got_q[0].cyc, exp_q[0].cyc); else n_pass++;
    step(1'b0, 1'b0, 0);
    n_chk++; if (sym_valid !== 1'b0) $display("FAIL cos_pulse_width got=%b want=0", sym_valid); else n_pass++;
  endtask

  task automatic test_neg_cos();
    clear_q();
    send(1, 0, 1'b1, 1'b0);
    pad_q(1);
    n_chk++; if (got_q[0].sym !== 4'b0100) $display("FAIL ncos_sym got=%b want=0100", got_q[0].sym); else n_pass++;
    n_chk++; if (got_q[0].i !== -516072) $display("FAIL ncos_isoft got=%0d want=-516072", got_q[0].i); else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_q();
    send(2, 0, 1'b1, 1'b0);
    send(3, 0, 1'b1, 1'b0);
    n_chk++; if (got_q.size() != 2) $display("FAIL b2b_dumps got=%0d want=2", got_q.size()); else n_pass++;
    pad_q(2);
    n_chk++; if (got_q[0].sym !== 4'b1101) $display("FAIL b2b_sym0 got=%b want=1101", got_q[0].sym); else n_pass++;
    n_chk++; if (got_q[1].sym !== 4'b1000) $display("FAIL b2b_sym1 got=%b want=1000", got_q[1].sym); else n_pass++;
    n_chk++; if (got_q[1].q !== -516072) $display("FAIL b2b_qsoft1 got=%0d want=-516072", got_q[1].q); else n_pass++;
    n_chk++; if (got_q[1].cyc - got_q[0].cyc !== SYM_LEN)
      $display("FAIL b2b_spacing got=%0d want=%0d", got_q[1].cyc - got_q[0].cyc, SYM_LEN); else n_pass++;
  endtask

  task automatic test_gaps();
    clear_q();
    send(0, 30, 1'b1, 1'b0);
    n_chk++; if (got_q.size() != 1) $display("FAIL gap_dumps got=%0d want=1", got_q.size()); else n_pass++;
    pad_q(1);
    n_chk++; if (got_q[0].sym !== 4'b1110) $display("FAIL gap_sym got=%b want=1110", got_q[0].sym); else n_pass++;
    n_chk++; if (got_q[0].i !== 516072) $display("FAIL gap_isoft got=%0d want=516072", got_q[0].i); else n_pass++;
    n_chk++; if (got_q[0].cyc !== exp_q[0].cyc) $display("FAIL gap_latency got=%0d want=%0d", got_q[0].cyc, exp_q[0].cyc); else n_pass++;
  endtask

  task automatic test_resync();
    int c0;
    clear_q();
    for (int n = 0; n < 20; n++) step(n == 0, 1'b1, wave(1, n));
    c0 = cyc;
    send(0, 0, 1'b1, 1'b0);
    n_chk++; if (got_q.size() != 1) $display("FAIL resync_dumps got=%0d want=1", got_q.size()); else n_pass++;
    pad_q(1);
    n_chk++; if (got_q[0].cyc !== c0 + SYM_LEN) $display("FAIL resync_latency got=%0d want=%0d", got_q[0].cyc, c0 + SYM_LEN); else n_pass++;
    n_chk++; if (got_q[0].sym !== 4'b1110) $display("FAIL resync_sym got=%b want=1110", got_q[0].sym); else n_pass++;
  endtask

  task automatic test_sync_on_last();
    clear_q();
    send(0, 0, 1'b1, 1'b1);
    send(1, 0, 1'b0, 1'b0);
    n_chk++; if (got_q.size() != 2) $display("FAIL synclast_dumps got=%0d want=2", got_q.size()); else n_pass++;
    pad_q(2);
    n_chk++; if (got_q[0].sym !== 4'b1110) $display("FAIL synclast_sym0 got=%b want=1110", got_q[0].sym); else n_pass++;
    n_chk++; if (got_q[1].sym !== 4'b0100) $display("FAIL synclast_sym1 got=%b want=0100", got_q[1].sym); else n_pass++;
  endtask

  task automatic test_random();
    clear_q();
    for (int s = 0; s < 6; s++) send(5, 20, s == 0, 1'b0);
    n_chk++; if (got_q.size() != exp_q.size()) $display("FAIL rnd_dumps got=%0d want=%0d", got_q.size(), exp_q.size()); else n_pass++;
    pad_q(6);
    for (int k = 0; k < 6; k++) begin
      n_chk++; if (got_q[k].sym !== exp_q[k].sym) $display("FAIL rnd_sym%0d got=%b want=%b", k, got_q[k].sym, exp_q[k].sym); else n_pass++;
      n_chk++; if (got_q[k].i !== exp_q[k].i) $display("FAIL rnd_isoft%0d got=%0d want=%0d", k, got_q[k].i, exp_q[k].i); else n_pass++;
      n_chk++; if (got_q[k].q !== exp_q[k].q) $display("FAIL rnd_qsoft%0d got=%0d want=%0d", k, got_q[k].q, exp_q[k].q); else n_pass++;
      n_chk++; if (got_q[k].cyc !== exp_q[k].cyc) $display("FAIL rnd_cyc%0d got=%0d want=%0d", k, got_q[k].cyc, exp_q[k].cyc); else n_pass++;
    end
  endtask

`ifdef DEMOD_ACC_SAT_EN
  task automatic test_sat();
    clear_q();
    send(4, 0, 1'b1, 1'b0);
    send(0, 0, 1'b1, 1'b0);
    pad_q(2);
    n_chk++; if (got_q[0].i !== 524287) $display("FAIL sat_isoft got=%0d want=524287", got_q[0].i); else n_pass++;
    n_chk++; if (got_q[0].sat !== 1'b1) $display("FAIL sat_flag_set got=%b want=1", got_q[0].sat); else n_pass++;
    n_chk++; if (got_q[0].q !== exp_q[0].q) $display("FAIL sat_qsoft got=%0d want=%0d", got_q[0].q, exp_q[0].q); else n_pass++;
    n_chk++; if (got_q[1].sat !== 1'b0) $display("FAIL sat_flag_clear got=%b want=0", got_q[1].sat); else n_pass++;
    n_chk++; if (got_q[1].i !== 516072) $display("FAIL sat_clean_isoft got=%0d want=516072", got_q[1].i); else n_pass++;
  endtask
`endif

  initial begin
    for (int k = 0; k < CARR_LEN; k++) begin
      cosv[k] = int'(127.0 * $cos(2.0 * 3.14159265358979 * k / CARR_LEN));
      sinv[k] = int'(127.0 * $sin(2.0 * 3.14159265358979 * k / CARR_LEN));
    end
    test_reset();
    test_cos();
    test_neg_cos();
    test_back_to_back();
    test_gaps();
    test_resync();
    test_sync_on_last();
    test_random();
`ifdef DEMOD_ACC_SAT_EN
    test_sat();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
